// File: rtl/spx_issue_collect_pkg.sv
// ============================================================================
// Module : spx_pkg
// Brief  : Shared constants and mode encoding for the softplus/exp issue path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spx_pkg;

  localparam int DW = 16;

  localparam logic [15:0] FP16_ONE     = 16'h3C00;
  localparam logic [15:0] FP16_LN2     = 16'h398C;
  localparam logic [15:0] FP16_INV_LN2 = 16'h3DC5;

  localparam logic MODE_SP = 1'b1;
  localparam logic MODE_EX = 1'b0;

endpackage

`default_nettype wire

// File: rtl/spx_issue_collect_fifo.sv
// ============================================================================
// Module : spx_fifo
// Brief  : First-word-fall-through result FIFO; head is presented while non-empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spx_fifo #(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  import spx_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_ready && !empty;

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/spx_issue_collect.sv
// ============================================================================
// Module : spx_issue_collect
// Brief  : Merges softplus/exp request streams onto the shared fp16 unit and
//          collects its no-stall results into credit-protected per-mode FIFOs.
//          Optional perf counters enabled by SPX_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spx_issue_collect #(
  parameter int DW         = spx_pkg::DW,
  parameter int FIFO_DEPTH = 32,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sp_valid_i,
  output logic          sp_ready_o,
  input  logic [DW-1:0] sp_x_i,
  input  logic          ex_valid_i,
  output logic          ex_ready_o,
  input  logic [DW-1:0] ex_x_i,
  output logic          u_valid_o,
  output logic          u_mode_softplus_o,
  output logic [DW-1:0] u_x_o,
  input  logic [DW-1:0] u_y_S_i,
  input  logic          u_valid_S_i,
  input  logic [DW-1:0] u_y_e_i,
  input  logic          u_valid_e_i,
  output logic          sp_valid_o,
  input  logic          sp_ready_i,
  output logic [DW-1:0] sp_y_o,
  output logic          ex_valid_o,
  input  logic          ex_ready_i,
  output logic [DW-1:0] ex_y_o,
`ifdef SPX_PERF_CNT_EN
  output logic [31:0]   perf_sp_o,
  output logic [31:0]   perf_ex_o,
  output logic [31:0]   perf_stall_o,
`endif
  output logic          busy_o,
  output logic          err_o
);
  import spx_pkg::*;

  localparam logic [CW-1:0] CRD_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic          elig_sp, elig_ex;
  logic          req_sp, req_ex;
  logic          grant_sp, grant_ex;
  logic          rr_sp;
  logic          pop_sp, pop_ex;
  logic          issue_sp, issue_ex;
  logic          res_sp_ok, res_ex_ok;
  logic          full_sp, full_ex;
  logic          empty_sp, empty_ex;
  logic [CW-1:0] crd_sp, crd_ex;
  logic [CW-1:0] inf_sp, inf_ex;

  // Credits count tokens from grant until output pop, so a granted request
  // always finds FIFO space however long the consumer stalls.
  assign elig_sp = (crd_sp < CRD_MAX);
  assign elig_ex = (crd_ex < CRD_MAX);
  assign req_sp  = sp_valid_i && elig_sp;
  assign req_ex  = ex_valid_i && elig_ex;

  assign grant_sp = req_sp && (!req_ex || rr_sp);
  assign grant_ex = req_ex && (!req_sp || !rr_sp);

  assign sp_ready_o = grant_sp;
  assign ex_ready_o = grant_ex;

  assign pop_sp = sp_valid_o && sp_ready_i;
  assign pop_ex = ex_valid_o && ex_ready_i;

  assign issue_sp = u_valid_o && (u_mode_softplus_o == MODE_SP);
  assign issue_ex = u_valid_o && (u_mode_softplus_o == MODE_EX);

  assign res_sp_ok = u_valid_S_i && (inf_sp != '0);
  assign res_ex_ok = u_valid_e_i && (inf_ex != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_sp <= 1'b1;
    end else if (grant_sp) begin
      rr_sp <= 1'b0;
    end else if (grant_ex) begin
      rr_sp <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_valid_o         <= 1'b0;
      u_mode_softplus_o <= 1'b0;
      u_x_o             <= '0;
    end else begin
      u_valid_o <= grant_sp || grant_ex;
      if (grant_sp) begin
        u_mode_softplus_o <= MODE_SP;
        u_x_o             <= sp_x_i;
      end else if (grant_ex) begin
        u_mode_softplus_o <= MODE_EX;
        u_x_o             <= ex_x_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crd_sp <= '0;
      crd_ex <= '0;
    end else begin
      if (grant_sp && !pop_sp) crd_sp <= crd_sp + ONE;
      else if (!grant_sp && pop_sp) crd_sp <= crd_sp - ONE;
      if (grant_ex && !pop_ex) crd_ex <= crd_ex + ONE;
      else if (!grant_ex && pop_ex) crd_ex <= crd_ex - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inf_sp <= '0;
      inf_ex <= '0;
    end else begin
      if (issue_sp && !res_sp_ok) inf_sp <= inf_sp + ONE;
      else if (!issue_sp && res_sp_ok) inf_sp <= inf_sp - ONE;
      if (issue_ex && !res_ex_ok) inf_ex <= inf_ex + ONE;
      else if (!issue_ex && res_ex_ok) inf_ex <= inf_ex - ONE;
    end
  end

  // Results with nothing in flight (e.g. stale after reset) or landing on a
  // full FIFO are discarded and latched as an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if ((u_valid_S_i && !res_sp_ok) || (u_valid_e_i && !res_ex_ok) ||
                 (res_sp_ok && full_sp) || (res_ex_ok && full_ex)) begin
      err_o <= 1'b1;
    end
  end

  spx_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_sp (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (res_sp_ok),
    .wr_data  (u_y_S_i),
    .rd_valid (sp_valid_o),
    .rd_ready (sp_ready_i),
    .rd_data  (sp_y_o),
    .full     (full_sp),
    .empty    (empty_sp)
  );

  spx_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_ex (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (res_ex_ok),
    .wr_data  (u_y_e_i),
    .rd_valid (ex_valid_o),
    .rd_ready (ex_ready_i),
    .rd_data  (ex_y_o),
    .full     (full_ex),
    .empty    (empty_ex)
  );

  assign busy_o = (inf_sp != '0) || (inf_ex != '0) || !empty_sp || !empty_ex || u_valid_o;

`ifdef SPX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_sp_o    <= '0;
      perf_ex_o    <= '0;
      perf_stall_o <= '0;
    end else begin
      if (grant_sp) perf_sp_o <= perf_sp_o + 32'd1;
      if (grant_ex) perf_ex_o <= perf_ex_o + 32'd1;
      if ((sp_valid_i && !elig_sp) || (ex_valid_i && !elig_ex))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spx_issue_collect.sv
// ============================================================================
// Module : tb_spx_issue_collect
// Brief  : Self-checking bench with a stub fp16 unit and per-mode scoreboards.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spx_issue_collect;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sp_valid_i, sp_ready_o, ex_valid_i, ex_ready_o;
  logic [DW-1:0] sp_x_i, ex_x_i;
  logic          u_valid_o, u_mode_softplus_o;
  logic [DW-1:0] u_x_o, u_y_S_i, u_y_e_i;
  logic          u_valid_S_i, u_valid_e_i;
  logic          sp_valid_o, sp_ready_i, ex_valid_o, ex_ready_i;
  logic [DW-1:0] sp_y_o, ex_y_o;
  logic          busy_o, err_o;
`ifdef SPX_PERF_CNT_EN
  logic [31:0]   perf_sp_o, perf_ex_o, perf_stall_o;
`endif

  always #5 clk = ~clk;

  spx_issue_collect dut (
    .clk(clk), .rst(rst),
    .sp_valid_i(sp_valid_i), .sp_ready_o(sp_ready_o), .sp_x_i(sp_x_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_x_i(ex_x_i),
    .u_valid_o(u_valid_o), .u_mode_softplus_o(u_mode_softplus_o), .u_x_o(u_x_o),
    .u_y_S_i(u_y_S_i), .u_valid_S_i(u_valid_S_i),
    .u_y_e_i(u_y_e_i), .u_valid_e_i(u_valid_e_i),
    .sp_valid_o(sp_valid_o), .sp_ready_i(sp_ready_i), .sp_y_o(sp_y_o),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_y_o(ex_y_o),
`ifdef SPX_PERF_CNT_EN
    .perf_sp_o(perf_sp_o), .perf_ex_o(perf_ex_o), .perf_stall_o(perf_stall_o),
`endif
    .busy_o(busy_o), .err_o(err_o)
  );

  // Stub unit: exp returns x after 13 cycles, softplus returns x^8000 after 16.
  logic [12:0]   pv_e;
  logic [15:0]   pv_s;
  logic [DW-1:0] pd_e [13];
  logic [DW-1:0] pd_s [16];
  logic          inj_e;
  logic [DW-1:0] inj_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_e <= '0;
      pv_s <= '0;
    end else begin
      pv_e <= {pv_e[11:0], u_valid_o & ~u_mode_softplus_o};
      pv_s <= {pv_s[14:0], u_valid_o & u_mode_softplus_o};
    end
  end

  always @(posedge clk) begin
    pd_e[0] <= u_x_o;
    pd_s[0] <= u_x_o;
    for (int i = 1; i < 13; i++) pd_e[i] <= pd_e[i-1];
    for (int i = 1; i < 16; i++) pd_s[i] <= pd_s[i-1];
  end

  assign u_valid_e_i = pv_e[12] | inj_e;
  assign u_y_e_i     = inj_e ? inj_d : pd_e[12];
  assign u_valid_S_i = pv_s[15];
  assign u_y_S_i     = pd_s[15] ^ 16'h8000;

  int checks = 0;
  int errors = 0;
  int sp_grants, ex_grants;
  logic [DW-1:0] sp_q[$];
  logic [DW-1:0] ex_q[$];

  typedef struct {
    logic          sp_v;
    logic [DW-1:0] sp_x;
    logic          ex_v;
    logic [DW-1:0] ex_x;
    logic          rsp;
    logic          rex;
    logic          uv;
    logic          um;
    logic [DW-1:0] ux;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshake monitor: pushes model results at grant, compares at pop.
  task automatic monitor();
    logic [DW-1:0] e;
    if (sp_ready_o && ex_ready_o) chk("grant_exclusive", 1, 0);
    if (sp_valid_i && sp_ready_o) begin sp_q.push_back(sp_x_i ^ 16'h8000); sp_grants++; end
    if (ex_valid_i && ex_ready_o) begin ex_q.push_back(ex_x_i); ex_grants++; end
    if (sp_valid_o && sp_ready_i) begin
      if (sp_q.size() == 0) chk("sp_unexpected", 1, 0);
      else begin e = sp_q.pop_front(); chk("sp_y", sp_y_o, e); end
    end
    if (ex_valid_o && ex_ready_i) begin
      if (ex_q.size() == 0) chk("ex_unexpected", 1, 0);
      else begin e = ex_q.pop_front(); chk("ex_y", ex_y_o, e); end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sp_valid_i = 0; ex_valid_i = 0; sp_x_i = '0; ex_x_i = '0;
    sp_ready_i = 1; ex_ready_i = 1; inj_e = 0; inj_d = '0;
    sp_q.delete(); ex_q.delete();
    sp_grants = 0; ex_grants = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (sp_q.size() != 0 || ex_q.size() != 0); i++) tick();
    chk("drain_sp_q_empty", sp_q.size(), 0);
    chk("drain_ex_q_empty", ex_q.size(), 0);
  endtask

  initial begin
    int  k;
    logic sp_seen;

    tbl[0] = '{1'b0, 16'h0000, 1'b1, 16'h3800, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 16'h3800, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3800};
    tbl[2] = '{1'b1, 16'h3C00, 1'b1, 16'hC000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3800};
    tbl[3] = '{1'b1, 16'h3C00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'hC000};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3C00};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

    // Reset state
    do_reset();
    chk("rst_u_valid", u_valid_o, 0);
    chk("rst_u_x", u_x_o, 0);
    chk("rst_u_mode", u_mode_softplus_o, 0);
    chk("rst_sp_valid", sp_valid_o, 0);
    chk("rst_ex_valid", ex_valid_o, 0);
    chk("rst_sp_y", sp_y_o, 0);
    chk("rst_ex_y", ex_y_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);

    // Single exp request: latency 15 to the output
    ex_valid_i = 1; ex_x_i = 16'h3C00;
    #1 chk("single_ex_ready", ex_ready_o, 1);
    tick();
    ex_valid_i = 0;
    chk("single_u_valid", u_valid_o, 1);
    chk("single_u_mode", u_mode_softplus_o, 0);
    chk("single_u_x", u_x_o, 16'h3C00);
    chk("single_busy", busy_o, 1);
    k = 1; sp_seen = 0;
    while (!ex_valid_o && k < 40) begin
      if (sp_valid_o) sp_seen = 1;
      tick();
      k++;
    end
    chk("single_latency", k, 15);
    chk("single_ex_y", ex_y_o, 16'h3C00);
    tick();
    chk("single_sp_silent", sp_seen, 0);
    chk("single_idle", busy_o, 0);

    // Alternating burst via table
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sp_valid_i = tbl[i].sp_v; sp_x_i = tbl[i].sp_x;
      ex_valid_i = tbl[i].ex_v; ex_x_i = tbl[i].ex_x;
      #1;
      chk($sformatf("burst%0d_sp_ready", i), sp_ready_o, tbl[i].rsp);
      chk($sformatf("burst%0d_ex_ready", i), ex_ready_o, tbl[i].rex);
      chk($sformatf("burst%0d_u_valid", i), u_valid_o, tbl[i].uv);
      if (tbl[i].uv) begin
        chk($sformatf("burst%0d_u_mode", i), u_mode_softplus_o, tbl[i].um);
        chk($sformatf("burst%0d_u_x", i), u_x_o, tbl[i].ux);
      end
      tick();
    end
    drain(60);
`ifdef SPX_PERF_CNT_EN
    chk("perf_sp", perf_sp_o, 2);
    chk("perf_ex", perf_ex_o, 2);
`endif

    // Simultaneous unit results, then grant and pop in one cycle
    do_reset();
    sp_valid_i = 1; sp_x_i = 16'h4000;
    #1 chk("same_sp_ready", sp_ready_o, 1);
    tick();
    sp_valid_i = 0;
    tick(); tick();
    ex_valid_i = 1; ex_x_i = 16'h4400;
    #1 chk("same_ex_ready", ex_ready_o, 1);
    tick();
    ex_valid_i = 0;
    k = 0;
    while (!u_valid_e_i && k < 40) begin tick(); k++; end
    chk("same_both_results", {u_valid_S_i, u_valid_e_i}, 2'b11);
    tick();
    sp_valid_i = 1; sp_x_i = 16'h4800;
    #1;
    chk("same_pop_sp_valid", sp_valid_o, 1);
    chk("same_pop_ex_valid", ex_valid_o, 1);
    chk("same_grant_with_pop", sp_ready_o, 1);
    tick();
    sp_valid_i = 0;
    drain(60);
    chk("same_busy_done", busy_o, 0);
    chk("same_err", err_o, 0);

    // Exp backpressure: credits stop at FIFO depth, softplus unaffected
    do_reset();
    ex_ready_i = 0; ex_valid_i = 1;
    for (int i = 0; i < 50; i++) begin
      ex_x_i = 16'h1000 + 16'(ex_grants);
      tick();
    end
    chk("bp_grants", ex_grants, 32);
    #1 chk("bp_ex_ready_blocked", ex_ready_o, 0);
    sp_valid_i = 1; sp_x_i = 16'h2000;
    #1 chk("bp_sp_still_granted", sp_ready_o, 1);
    tick();
    sp_valid_i = 0;
    chk("bp_ex_valid_held", ex_valid_o, 1);
    chk("bp_ex_y_held", ex_y_o, 16'h1000);
    ex_ready_i = 1;
    for (int i = 0; i < 200 && ex_grants < 40; i++) begin
      ex_x_i = 16'h1000 + 16'(ex_grants);
      tick();
    end
    ex_valid_i = 0;
    drain(200);
    chk("bp_total_grants", ex_grants, 40);
    chk("bp_err", err_o, 0);

    // Spurious unit result right after reset
    do_reset();
    chk("spur_err_before", err_o, 0);
    inj_e = 1; inj_d = 16'h1234;
    tick();
    inj_e = 0;
    chk("spur_err_set", err_o, 1);
    sp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (ex_valid_o) sp_seen = 1;
      tick();
    end
    chk("spur_ex_valid_never", sp_seen, 0);
    chk("spur_err_sticky", err_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
